rcpu_io_uart: RTL and testbench

- UART peripheral that acts as the responder on the CPU's SYS I/O bus.
- It decodes the CPU's single-cycle read/write strobes into three word-aligned registers: DATA, STATUS and DIVISOR.
- Transmit path: 4-entry TX FIFO feeding an 8N1 serializer.
- Receive path: 8N1 deserializer feeding a 1-byte holding register.
- Sits beside the memory on the CPU's I/O port and drives the board's serial pins.

---
 rtl/rcpu_io_uart.sv | 262 ++++++++++++++++++++++++++
 tb/tb_rcpu_io_uart.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcpu_io_uart.sv
// UART responder on the CPU SYS I/O bus: DATA/STATUS/DIVISOR registers,
// TX FIFO feeding an 8N1 serializer and an 8N1 deserializer with a 1-byte holding register.
module rcpu_io_uart #(
    parameter logic [15:0] BASE_ADDR     = 16'h0000,
    parameter logic [15:0] DIVISOR_RESET = 16'd103,
    parameter int          TX_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_read_enable,
    input  logic        io_write_enable,
    input  logic [15:0] io_address,
    input  logic [15:0] io_write_data,
    output logic [15:0] io_read_data,
    output logic        uart_tx,
    input  logic        uart_rx
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(TX_DEPTH);

    // ---------------- bus decode ----------------
    logic       hit;
    logic [1:0] sel;
    logic       rd_data, wr_data, wr_status, wr_div;
    logic       unused_addr_bits;

    assign hit       = (io_address[15:4] == BASE_ADDR[15:4]);
    assign sel       = io_address[3:2];
    assign rd_data   = io_read_enable  & hit & (sel == 2'd0);
    assign wr_data   = io_write_enable & hit & (sel == 2'd0);
    assign wr_status = io_write_enable & hit & (sel == 2'd1);
    assign wr_div    = io_write_enable & hit & (sel == 2'd2);
    assign unused_addr_bits = ^io_address[1:0];

    logic [15:0] divisor;
    logic        rx_valid, rx_overrun, rx_frame_err, tx_drop;
    logic [7:0]  rx_byte;
    logic        tx_full, tx_empty, tx_busy;
    logic [15:0] rd_mux;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) divisor <= DIVISOR_RESET;
        else if (wr_div) divisor <= io_write_data;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        rd_mux = '0;
        if (hit) begin
            case (sel)
                2'd0:    rd_mux = rx_valid ? {8'h00, rx_byte} : 16'h0000;
                2'd1:    rd_mux = {9'b0, rx_frame_err, tx_drop, tx_busy, tx_empty,
                                   tx_full, rx_overrun, rx_valid};
                2'd2:    rd_mux = divisor;
                default: rd_mux = '0;
            endcase
        end
    end

    // Read data reflects register state before this cycle's updates.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) io_read_data <= '0;
        else if (io_read_enable) io_read_data <= rd_mux;
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]       fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_count;
    logic             push, pop;
    uart_state_t      tx_state, tx_state_next;

    assign tx_full  = (fifo_count == FIFO_FULL_CNT);
    assign tx_empty = (fifo_count == '0);
    assign tx_busy  = (tx_state != S_IDLE);
    assign push     = wr_data & ~tx_full;
    assign pop      = (tx_state == S_IDLE) & ~tx_empty;

    // NOTE: FIFO storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= io_write_data[7:0];
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) tx_drop <= 1'b0;
        else if (wr_data && tx_full) tx_drop <= 1'b1;
        else if (wr_status && io_write_data[5]) tx_drop <= 1'b0;
    end

    // ---------------- TX serializer ----------------
    logic [15:0] tx_cnt, tx_cnt_next;
    logic [7:0]  tx_shift, tx_shift_next;
    logic [2:0]  tx_bit, tx_bit_next;
    logic        tx_line_next;

    always_comb begin
        tx_state_next = tx_state;
        tx_cnt_next   = tx_cnt;
        tx_shift_next = tx_shift;
        tx_bit_next   = tx_bit;
        case (tx_state)
            S_IDLE: if (!tx_empty) begin
                tx_state_next = S_START;
                tx_cnt_next   = divisor;
                tx_shift_next = fifo_mem[rd_ptr];
                tx_bit_next   = 3'd0;
            end
            S_START: if (tx_cnt == 16'd0) begin
                tx_state_next = S_DATA;
                tx_cnt_next   = divisor;
            end else tx_cnt_next = tx_cnt - 16'd1;
            S_DATA: if (tx_cnt == 16'd0) begin
                tx_cnt_next = divisor;
                if (tx_bit == 3'd7) tx_state_next = S_STOP;
                else begin
                    tx_bit_next   = tx_bit + 3'd1;
                    tx_shift_next = {1'b0, tx_shift[7:1]};
                end
            end else tx_cnt_next = tx_cnt - 16'd1;
            S_STOP: if (tx_cnt == 16'd0) tx_state_next = S_IDLE;
                    else tx_cnt_next = tx_cnt - 16'd1;
            default: tx_state_next = S_IDLE;
        endcase
        // Line level is registered alongside the state so the pin never glitches.
        case (tx_state_next)
            S_START: tx_line_next = 1'b0;
            S_DATA:  tx_line_next = tx_shift_next[0];
            default: tx_line_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_cnt   <= tx_cnt_next;
            tx_shift <= tx_shift_next;
            tx_bit   <= tx_bit_next;
            uart_tx  <= tx_line_next;
        end
    end

    // ---------------- RX deserializer ----------------
    logic        rx_meta, rx_sync, rx_prev;
    uart_state_t rx_state, rx_state_next;
    logic [15:0] rx_cnt, rx_cnt_next, rx_half, rx_first;
    logic [16:0] rx_div_inc;
    logic [7:0]  rx_shift, rx_shift_next;
    logic [2:0]  rx_bit, rx_bit_next;
    logic        rx_load, rx_ferr_evt;

    assign rx_div_inc = {1'b0, divisor} + 17'd1;
    assign rx_half    = rx_div_inc[16:1];
    // The detect cycle itself counts towards the half-bit wait.
    assign rx_first   = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_shift_next = rx_shift;
        rx_bit_next   = rx_bit;
        rx_load       = 1'b0;
        rx_ferr_evt   = 1'b0;
        case (rx_state)
            S_IDLE: if (rx_prev && !rx_sync) begin
                rx_state_next = S_START;
                rx_cnt_next   = rx_first;
                rx_bit_next   = 3'd0;
            end
            S_START: if (rx_cnt == 16'd0) begin
                rx_state_next = rx_sync ? S_IDLE : S_DATA;
                rx_cnt_next   = divisor;
            end else rx_cnt_next = rx_cnt - 16'd1;
            S_DATA: if (rx_cnt == 16'd0) begin
                rx_shift_next = {rx_sync, rx_shift[7:1]};
                rx_cnt_next   = divisor;
                if (rx_bit == 3'd7) rx_state_next = S_STOP;
                else rx_bit_next = rx_bit + 3'd1;
            end else rx_cnt_next = rx_cnt - 16'd1;
            S_STOP: if (rx_cnt == 16'd0) begin
                rx_state_next = S_IDLE;
                rx_load       = rx_sync;
                rx_ferr_evt   = ~rx_sync;
            end else rx_cnt_next = rx_cnt - 16'd1;
            default: rx_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_cnt   <= rx_cnt_next;
            rx_shift <= rx_shift_next;
            rx_bit   <= rx_bit_next;
        end
    end

    // A DATA read empties the holding register, so a same-cycle load is accepted.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            rx_valid     <= 1'b0;
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_byte      <= '0;
        end else begin
            if (rd_data) begin
                rx_valid     <= 1'b0;
                rx_overrun   <= 1'b0;
                rx_frame_err <= 1'b0;
            end
            if (rx_ferr_evt) rx_frame_err <= 1'b1;
            if (rx_load) begin
                if (!rx_valid || rd_data) begin
                    rx_byte  <= rx_shift_next;
                    rx_valid <= 1'b1;
                end else rx_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rcpu_io_uart.sv
// Self-checking bench for rcpu_io_uart: bus register access, TX framing and FIFO,
// RX framing, overrun, glitch and frame-error handling against a behavioural model.
module tb_rcpu_io_uart;

    localparam logic [15:0] DATA_A = 16'h0000;
    localparam logic [15:0] STAT_A = 16'h0004;
    localparam logic [15:0] DIV_A  = 16'h0008;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_read_enable = 1'b0;
    logic        io_write_enable = 1'b0;
    logic [15:0] io_address = '0;
    logic [15:0] io_write_data = '0;
    logic [15:0] io_read_data;
    logic        uart_tx;
    logic        uart_rx = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    rcpu_io_uart #(
        .BASE_ADDR(16'h0000), .DIVISOR_RESET(16'd103), .TX_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .resetq(resetq),
        .io_read_enable(io_read_enable), .io_write_enable(io_write_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .uart_tx(uart_tx), .uart_rx(uart_rx)
    );

    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Behavioural model of the RX holding register and flags.
    bit         m_rx_valid, m_ovr, m_ferr;
    logic [7:0] m_rx_byte;

    task automatic model_frame(input logic [7:0] b, input bit stop_ok);
        if (!stop_ok) m_ferr = 1'b1;
        else if (!m_rx_valid) begin
            m_rx_byte  = b;
            m_rx_valid = 1'b1;
        end else m_ovr = 1'b1;
    endtask

    task automatic model_data_read(output logic [15:0] v);
        v = m_rx_valid ? {8'h00, m_rx_byte} : 16'h0000;
        m_rx_valid = 1'b0;
        m_ovr      = 1'b0;
        m_ferr     = 1'b0;
    endtask

    function automatic logic [15:0] model_status(input bit busy, input int fifo_n, input bit drop);
        logic [15:0] s;
        s = '0;
        s[0] = m_rx_valid;
        s[1] = m_ovr;
        s[2] = (fifo_n == DEPTH);
        s[3] = (fifo_n == 0);
        s[4] = busy;
        s[5] = drop;
        s[6] = m_ferr;
        return s;
    endfunction

    // Serial line monitor: decodes frames on uart_tx into tx_q.
    logic [7:0] tx_q[$];
    int         mon_bit = 4;
    bit         mon_en  = 1'b0;

    initial begin : tx_monitor
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (mon_en && uart_tx === 1'b0) begin
                repeat (mon_bit / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (mon_bit) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (mon_bit) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        io_address = a; io_write_data = d; io_write_enable = 1'b1;
        @(negedge clk);
        io_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        io_address = a; io_read_enable = 1'b1;
        @(negedge clk);
        io_read_enable = 1'b0;
        @(negedge clk);
        d = io_read_data;
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_bit, input int d);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (d + 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (d + 1) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (d + 1) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * (d + 1)) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        n_checks++;
        if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
        n_checks++;
        if (io_read_data !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", io_read_data); else n_pass++;
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL reset_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        bus_read(DIV_A, v);
        n_checks++;
        if (v !== 16'd103) $display("FAIL reset_divisor: got %0d want 103", v); else n_pass++;
    endtask

    task automatic test_decode;
        logic [15:0] v;
        @(negedge clk);
        io_address = DIV_A; io_write_data = 16'd9;
        io_read_enable = 1'b1; io_write_enable = 1'b1;
        @(negedge clk);
        io_read_enable = 1'b0; io_write_enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if (io_read_data !== 16'd103) $display("FAIL rw_same_read: got %0d want 103", io_read_data); else n_pass++;
        bus_write(STAT_A, 16'h0000);
        repeat (3) @(negedge clk);
        n_checks++;
        if (io_read_data !== 16'd103) $display("FAIL read_hold: got %0d want 103", io_read_data); else n_pass++;
        bus_read(DIV_A, v);
        n_checks++;
        if (v !== 16'd9) $display("FAIL rw_same_write: got %0d want 9", v); else n_pass++;
        bus_read(16'h000C, v);
        n_checks++;
        if (v !== 16'h0000) $display("FAIL offset3_read: got %h want 0000", v); else n_pass++;
        bus_write(16'h0018, 16'd5);
        bus_write(16'h000C, 16'd6);
        bus_read(DIV_A, v);
        n_checks++;
        if (v !== 16'd9) $display("FAIL foreign_write: got %0d want 9", v); else n_pass++;
    endtask

    task automatic test_tx_frame;
        logic [15:0] v, st;
        logic        wave[70];
        logic [9:0]  frame;
        int          first, d;
        d = 3;
        bus_write(DIV_A, 16'(d));
        tx_q.delete();
        mon_bit = d + 1;
        mon_en  = 1'b1;
        frame   = {1'b1, 8'hA5, 1'b0};
        bus_write(DATA_A, 16'h00A5);
        fork
            for (int i = 0; i < 70; i++) begin
                @(negedge clk);
                wave[i] = uart_tx;
            end
            begin
                repeat (10) @(negedge clk);
                bus_read(STAT_A, st);
            end
        join
        first = -1;
        for (int i = 0; i < 6; i++) if (first < 0 && wave[i] === 1'b0) first = i;
        n_checks++;
        if (first < 0) begin
            $display("FAIL tx_start_latency: got no low within 6 cycles want start bit");
            first = 0;
        end else n_pass++;
        for (int k = 0; k < 10; k++) begin
            bit ok;
            ok = 1'b1;
            for (int j = 0; j < d + 1; j++)
                if (wave[first + k * (d + 1) + j] !== frame[k]) ok = 1'b0;
            n_checks++;
            if (!ok) $display("FAIL tx_bit%0d: got %b want %b", k, wave[first + k * (d + 1)], frame[k]);
            else n_pass++;
        end
        n_checks++;
        if (wave[first + 10 * (d + 1)] !== 1'b1) $display("FAIL tx_idle_after: got %b want 1", wave[first + 10 * (d + 1)]); else n_pass++;
        n_checks++;
        if (st !== model_status(1, 0, 0)) $display("FAIL tx_busy_status: got %h want %h", st, model_status(1, 0, 0)); else n_pass++;
        n_checks++;
        if (tx_q.size() != 1 || tx_q[0] !== 8'hA5) $display("FAIL tx_monitor_byte: got %0d bytes want 1 byte a5", tx_q.size()); else n_pass++;
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL tx_done_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] v;
        logic [7:0]  bytes[8];
        int d, n, accepted, in_fifo, waited, budget;
        bit drop;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 3 : int'($urandom_range(2, 4));
            n = (it == 0) ? 6 : int'($urandom_range(1, 8));
            for (int i = 0; i < 8; i++) bytes[i] = (it == 0) ? 8'(8'h11 + i) : 8'($urandom);
            bus_write(DIV_A, 16'(d));
            tx_q.delete();
            mon_bit = d + 1;
            mon_en  = 1'b1;
            for (int i = 0; i < n; i++) begin
                @(negedge clk);
                io_address = DATA_A; io_write_data = {8'h00, bytes[i]}; io_write_enable = 1'b1;
            end
            @(negedge clk);
            io_write_enable = 1'b0;
            accepted = (n < DEPTH + 1) ? n : DEPTH + 1;
            in_fifo  = accepted - 1;
            drop     = (n > DEPTH + 1);
            bus_read(STAT_A, v);
            n_checks++;
            if (v !== model_status(1, in_fifo, drop)) $display("FAIL b2b_status it%0d: got %h want %h", it, v, model_status(1, in_fifo, drop)); else n_pass++;
            if (drop) begin
                bus_write(STAT_A, 16'h0020);
                bus_read(STAT_A, v);
                n_checks++;
                if (v !== model_status(1, in_fifo, 0)) $display("FAIL drop_clear it%0d: got %h want %h", it, v, model_status(1, in_fifo, 0)); else n_pass++;
            end
            budget = accepted * (11 * (d + 1) + 2) + 50;
            waited = 0;
            while (tx_q.size() < accepted && waited < budget) begin
                @(negedge clk);
                waited++;
            end
            repeat (3 * (d + 1)) @(negedge clk);
            n_checks++;
            if (tx_q.size() != accepted) $display("FAIL b2b_count it%0d: got %0d bytes want %0d", it, tx_q.size(), accepted); else n_pass++;
            for (int i = 0; i < accepted && i < tx_q.size(); i++) begin
                n_checks++;
                if (tx_q[i] !== bytes[i]) $display("FAIL b2b_byte it%0d.%0d: got %h want %h", it, i, tx_q[i], bytes[i]); else n_pass++;
            end
            bus_read(STAT_A, v);
            n_checks++;
            if (v !== model_status(0, 0, 0)) $display("FAIL b2b_idle it%0d: got %h want %h", it, v, model_status(0, 0, 0)); else n_pass++;
        end
        mon_en = 1'b0;
    endtask

    task automatic test_rx;
        logic [15:0] v, exp;
        logic [7:0]  b;
        int d;
        for (int it = 0; it < 4; it++) begin
            d = (it == 0) ? 7 : int'($urandom_range(3, 10));
            b = (it == 0) ? 8'h3C : 8'($urandom);
            bus_write(DIV_A, 16'(d));
            send_rx(b, 1'b1, d);
            model_frame(b, 1'b1);
            bus_read(STAT_A, v);
            n_checks++;
            if (v !== model_status(0, 0, 0)) $display("FAIL rx_status it%0d: got %h want %h", it, v, model_status(0, 0, 0)); else n_pass++;
            bus_read(DATA_A, v);
            model_data_read(exp);
            n_checks++;
            if (v !== exp) $display("FAIL rx_data it%0d: got %h want %h", it, v, exp); else n_pass++;
            bus_read(STAT_A, v);
            n_checks++;
            if (v !== model_status(0, 0, 0)) $display("FAIL rx_cleared it%0d: got %h want %h", it, v, model_status(0, 0, 0)); else n_pass++;
        end
    endtask

    task automatic test_rx_overrun;
        logic [15:0] v, exp;
        bus_write(DIV_A, 16'd7);
        send_rx(8'h3C, 1'b1, 7);
        model_frame(8'h3C, 1'b1);
        send_rx(8'h55, 1'b1, 7);
        model_frame(8'h55, 1'b1);
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL ovr_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        bus_read(DATA_A, v);
        model_data_read(exp);
        n_checks++;
        if (v !== exp) $display("FAIL ovr_data: got %h want %h", v, exp); else n_pass++;
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL ovr_cleared: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        bus_read(DATA_A, v);
        model_data_read(exp);
        n_checks++;
        if (v !== exp) $display("FAIL empty_data: got %h want %h", v, exp); else n_pass++;
    endtask

    task automatic test_rx_errors;
        logic [15:0] v, exp;
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL glitch_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        send_rx(8'hA3, 1'b0, 7);
        model_frame(8'hA3, 1'b0);
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL ferr_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        bus_read(DATA_A, v);
        model_data_read(exp);
        n_checks++;
        if (v !== exp) $display("FAIL ferr_data: got %h want %h", v, exp); else n_pass++;
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL ferr_cleared: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        logic [15:0] v;
        int lows;
        mon_en = 1'b0;
        bus_write(DIV_A, 16'd3);
        bus_write(DATA_A, 16'h0081);
        bus_write(DATA_A, 16'h0042);
        bus_write(DATA_A, 16'h0024);
        bus_read(STAT_A, v);
        repeat (6) @(negedge clk);
        resetq = 1'b0;
        #1;
        n_checks++;
        if (uart_tx !== 1'b1) $display("FAIL midreset_tx: got %b want 1", uart_tx); else n_pass++;
        n_checks++;
        if (io_read_data !== 16'h0000) $display("FAIL midreset_rdata: got %h want 0000", io_read_data); else n_pass++;
        @(negedge clk);
        resetq = 1'b1;
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
        end
        n_checks++;
        if (lows != 0) $display("FAIL midreset_line: got %0d low cycles want 0", lows); else n_pass++;
        bus_read(STAT_A, v);
        n_checks++;
        if (v !== model_status(0, 0, 0)) $display("FAIL midreset_status: got %h want %h", v, model_status(0, 0, 0)); else n_pass++;
        bus_read(DIV_A, v);
        n_checks++;
        if (v !== 16'd103) $display("FAIL midreset_divisor: got %0d want 103", v); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_decode;
        test_tx_frame;
        test_back_to_back;
        test_rx;
        test_rx_overrun;
        test_rx_errors;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
